// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell reused over WIDTH cycles, LSB first.
// Optional signed overflow output ovf enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  assign fa_s = sa[0] ^ sb[0] ^ carry;
  assign fa_c = (sa[0] & sb[0]) | (carry & (sa[0] ^ sb[0]));
  assign cout = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sum   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // result fills from the MSB side, so bit 0 lands last at LSB
          sum   <= {fa_s, sum[WIDTH-1:1]};
          carry <= fa_c;
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= carry ^ fa_c;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8).
// Reference: plain integer addition of the sampled operands.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  int dcount = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) dcount++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ref_add(input logic [7:0] x,
                                         input logic [7:0] y,
                                         input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[8:0];
  endfunction

  function automatic logic ref_ovf(input logic [7:0] x,
                                   input logic [7:0] y,
                                   input logic [7:0] s);
    return (x[7] == y[7]) && (s[7] != x[7]);
  endfunction

  task automatic do_op(input logic [7:0] x,
                       input logic [7:0] y,
                       input logic c,
                       input bit scr);
    int n;
    logic [8:0] r;
    r = ref_add(x, y, c);
    n = 0;
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      if (busy) n++;
      if (scr) begin
        a = 8'($urandom); b = 8'($urandom);
        cin = 1'($urandom); start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("op_done", 32'(done), 1);
    chk("op_busy_cycles", n, 8);
    chk("op_busy_in_done", 32'(busy), 0);
    chk("op_sum", 32'(sum), 32'(r[7:0]));
    chk("op_cout", 32'(cout), 32'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
    chk("op_ovf", 32'(ovf), 32'(ref_ovf(x, y, r[7:0])));
`endif
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("sum_hold", 32'(sum), 32'(r[7:0]));
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    int d0, gap, ops;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h00, 8'h00, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 0);
    do_op(8'hA5, 8'h5A, 1'b1, 0);
    do_op(8'hFF, 8'hFF, 1'b1, 0);

    do_op(8'h10, 8'h20, 1'b0, 0);
    d0 = dcount;
    do_op(8'h10, 8'h20, 1'b0, 1);
    repeat (5) @(negedge clk);
    chk("ignored_start_one_done", dcount - d0, 1);

    for (int i = 0; i < 30; i++)
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    @(negedge clk);
    a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dcount;
    repeat (20) @(negedge clk);
    chk("abort_no_done", dcount - d0, 0);
    do_op(8'h12, 8'h34, 1'b1, 0);

    @(negedge clk);
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    start = 1'b1;
    q.push_back(ref_add(a, b, cin));
    gap = 0;
    ops = 0;
    for (int k = 0; k < 200 && ops < 6; k++) begin
      @(negedge clk);
      gap++;
      if (done) begin
        e = q.pop_front();
        chk("b2b_sum", 32'(sum), 32'(e[7:0]));
        chk("b2b_cout", 32'(cout), 32'(e[8]));
        chk("b2b_period", gap, 9);
        gap = 0;
        ops++;
        if (ops < 6) begin
          a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
          q.push_back(ref_add(a, b, cin));
        end else begin
          start = 1'b0;
        end
      end else begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
    end
    start = 1'b0;
    chk("b2b_ops", ops, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
